// File: rtl/neuron_mac_z.sv
// Neuron weighted sum z = bias + sum(x*w) in Q3.4, rounded half-up and saturated to 8 bits.
// Optional NEURON_MAC_SAT_FLAG_EN adds sat_flag, marking results that were clamped.
module neuron_mac_z #(
   parameter int N_INPUTS  = 2,
   parameter int FRAC_BITS = 4,
   parameter int ACC_WIDTH = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] x_data,
   input  logic [7:0] w_data,
   input  logic [7:0] bias,
   output logic       z_valid,
   input  logic       z_ready,
   output logic [7:0] z_value,
   output logic       busy
`ifdef NEURON_MAC_SAT_FLAG_EN
   ,
   output logic       sat_flag
`endif
);

   localparam int CNT_W = $clog2(N_INPUTS + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_INPUTS);
   localparam int RW = ACC_WIDTH + 1;
   localparam logic signed [RW-1:0] HALF = RW'(2 ** (FRAC_BITS - 1));

   typedef enum logic [1:0] {IDLE, ACCUM, ROUND, OUT} state_t;

   state_t                        state_q, state_d;
   logic signed [ACC_WIDTH-1:0]   acc_q;
   logic        [CNT_W-1:0]       count_q;
   logic signed [15:0]            prod16;
   logic signed [ACC_WIDTH-1:0]   prod_ext;
   logic signed [ACC_WIDTH-1:0]   bias_ext;
   logic signed [RW-1:0]          rnd_sum;
   logic signed [RW-1:0]          r_val;
   logic                          sat_hi, sat_lo;
   logic        [7:0]             z_next;

   assign prod16   = $signed(x_data) * $signed(w_data);
   assign prod_ext = {{(ACC_WIDTH-16){prod16[15]}}, prod16};
   assign bias_ext = $signed({{(ACC_WIDTH-8){bias[7]}}, bias}) <<< FRAC_BITS;

   // One extra bit so adding the rounding constant can never wrap.
   assign rnd_sum = {acc_q[ACC_WIDTH-1], acc_q} + HALF;
   assign r_val   = rnd_sum >>> FRAC_BITS;
   assign sat_hi  = r_val > RW'(127);
   assign sat_lo  = r_val < RW'(-128);

   always_comb begin
      z_next = r_val[7:0];
      if (sat_hi)
         z_next = 8'h7F;
      else if (sat_lo)
         z_next = 8'h80;
   end

   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid)
               state_d = (N_INPUTS == 1) ? ROUND : ACCUM;
         end
         ACCUM: begin
            in_ready = 1'b1;
            if (in_valid && (count_q + CNT_W'(1)) == LAST_CNT)
               state_d = ROUND;
         end
         ROUND: state_d = OUT;
         OUT: begin
            if (z_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         count_q  <= '0;
         z_value  <= '0;
         z_valid  <= 1'b0;
`ifdef NEURON_MAC_SAT_FLAG_EN
         sat_flag <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  acc_q   <= bias_ext + prod_ext;
                  count_q <= CNT_W'(1);
               end
            end
            ACCUM: begin
               if (in_valid) begin
                  acc_q   <= acc_q + prod_ext;
                  count_q <= count_q + CNT_W'(1);
               end
            end
            ROUND: begin
               z_value  <= z_next;
               z_valid  <= 1'b1;
`ifdef NEURON_MAC_SAT_FLAG_EN
               sat_flag <= sat_hi | sat_lo;
`endif
            end
            OUT: begin
               if (z_ready)
                  z_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_neuron_mac_z.sv
// Self-checking bench: u_dut (N_INPUTS=2) and u_dut1 (N_INPUTS=1), scoreboard per instance.
module tb_neuron_mac_z;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0, in_ready;
   logic [7:0] x_data = '0, w_data = '0, bias = '0;
   logic       z_valid, z_ready = 1'b1, busy;
   logic [7:0] z_value;
   logic       in_valid1 = 1'b0, in_ready1;
   logic [7:0] x_data1 = '0, w_data1 = '0, bias1 = '0;
   logic       z_valid1, z_ready1 = 1'b1, busy1;
   logic [7:0] z_value1;
`ifdef NEURON_MAC_SAT_FLAG_EN
   logic       sat_flag, sat_flag1;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int acc_cyc = 0;
   int last_hs = 0;
   int hs_count = 0;
   int zv_cycles = 0;
   int hs_edges[$];
   logic [8:0] exp_q[$];
   logic [8:0] exp_q1[$];
   logic [8:0] e_mon, e_mon1;

   neuron_mac_z #(.N_INPUTS(2), .FRAC_BITS(4), .ACC_WIDTH(20)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .x_data(x_data), .w_data(w_data), .bias(bias),
      .z_valid(z_valid), .z_ready(z_ready), .z_value(z_value), .busy(busy)
`ifdef NEURON_MAC_SAT_FLAG_EN
      , .sat_flag(sat_flag)
`endif
   );

   neuron_mac_z #(.N_INPUTS(1), .FRAC_BITS(4), .ACC_WIDTH(20)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
      .x_data(x_data1), .w_data(w_data1), .bias(bias1),
      .z_valid(z_valid1), .z_ready(z_ready1), .z_value(z_value1), .busy(busy1)
`ifdef NEURON_MAC_SAT_FLAG_EN
      , .sat_flag(sat_flag1)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference: {sat, z} for a two-pair frame.
   function automatic logic [8:0] model(input logic [7:0] b, x0, w0, x1, w1);
      int acc, r;
      logic [7:0] z;
      logic sat;
      acc = $signed(b) * 16 + $signed(x0) * $signed(w0) + $signed(x1) * $signed(w1);
      r = (acc + 8) >>> 4;
      sat = (r > 127) || (r < -128);
      z = (r > 127) ? 8'h7F : (r < -128) ? 8'h80 : 8'(r);
      return {sat, z};
   endfunction

   always @(negedge clk) begin
      if (!rst && z_valid) zv_cycles++;
      if (!rst && z_valid && z_ready) begin
         hs_count++;
         last_hs = cyc + 1;
         hs_edges.push_back(cyc + 1);
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL spurious_z: got z_value=%0d, no output expected", $signed(z_value));
         end else begin
            e_mon = exp_q.pop_front();
            if (z_value !== e_mon[7:0]) begin
               errors++;
               $display("FAIL z_value: got %0d expected %0d", $signed(z_value), $signed(e_mon[7:0]));
            end
`ifdef NEURON_MAC_SAT_FLAG_EN
            checks++;
            if (sat_flag !== e_mon[8]) begin
               errors++;
               $display("FAIL sat_flag: got %0b expected %0b", sat_flag, e_mon[8]);
            end
`endif
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && z_valid1 && z_ready1) begin
         checks++;
         if (exp_q1.size() == 0) begin
            errors++;
            $display("FAIL spurious_z1: got z_value=%0d, no output expected", $signed(z_value1));
         end else begin
            e_mon1 = exp_q1.pop_front();
            if (z_value1 !== e_mon1[7:0]) begin
               errors++;
               $display("FAIL z_value1: got %0d expected %0d", $signed(z_value1), $signed(e_mon1[7:0]));
            end
`ifdef NEURON_MAC_SAT_FLAG_EN
            checks++;
            if (sat_flag1 !== e_mon1[8]) begin
               errors++;
               $display("FAIL sat_flag1: got %0b expected %0b", sat_flag1, e_mon1[8]);
            end
`endif
         end
      end
   end

   // Presents a pair and returns one cycle after it is accepted; in_valid is left high.
   task automatic send_pair(input logic [7:0] x, input logic [7:0] w, input logic [7:0] b);
      int n;
      x_data = x; w_data = w; bias = b; in_valid = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 40) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready=%0b expected 1 within 40 cycles", in_ready);
            break;
         end
      end
      @(posedge clk); #1;
      acc_cyc = cyc;
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({z_valid, busy, z_value} !== 10'b0) begin
         errors++;
         $display("FAIL reset_state: got zv=%0b busy=%0b z=%0d expected 0 0 0", z_valid, busy, z_value);
      end
      @(posedge clk); #1 rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || in_ready1 !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %0b/%0b expected 1/1", in_ready, in_ready1);
      end
   endtask

   task automatic test_xor();
      int hs0, zv0, last;
      hs0 = hs_count; zv0 = zv_cycles;
      exp_q.push_back({1'b0, 8'd48});
      send_pair(8'd16, 8'd32, 8'hF0);
      checks++;
      if (busy !== 1'b1) begin
         errors++; $display("FAIL busy_mid_frame: got %0b expected 1", busy);
      end
      send_pair(8'd16, 8'd32, 8'hF0);
      in_valid = 1'b0;
      last = acc_cyc;
      for (int i = 0; i < 20 && hs_count == hs0; i++) @(posedge clk);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (hs_count != hs0 + 1) begin
         errors++; $display("FAIL xor_handshakes: got %0d expected 1", hs_count - hs0);
      end
      checks++;
      if (last_hs - last != 2) begin
         errors++; $display("FAIL xor_latency: got %0d edges expected 2", last_hs - last);
      end
      checks++;
      if (zv_cycles - zv0 != 1) begin
         errors++; $display("FAIL xor_zvalid_width: got %0d cycles expected 1", zv_cycles - zv0);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL busy_idle: got %0b expected 0", busy);
      end
   endtask

   task automatic test_rounding();
      logic [7:0] ws[4]  = '{8'd8, 8'd7, 8'hF8, 8'hF7};
      logic [7:0] exps[4] = '{8'd1, 8'd0, 8'd0, 8'hFF};
      bias1 = 8'd0; x_data1 = 8'd1;
      for (int k = 0; k < 4; k++) begin
         exp_q1.push_back({1'b0, exps[k]});
         w_data1 = ws[k]; in_valid1 = 1'b1;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready1) break;
         end
         @(posedge clk); #1 in_valid1 = 1'b0;
         for (int i = 0; i < 20 && exp_q1.size() != 0; i++) @(posedge clk);
         #1;
         checks++;
         if (exp_q1.size() != 0) begin
            errors++; $display("FAIL round_timeout: case %0d got no output, expected %0d", k, $signed(exps[k]));
         end
      end
   endtask

   task automatic test_saturation();
      exp_q.push_back({1'b1, 8'h7F});
      send_pair(8'd127, 8'd127, 8'd0);
      send_pair(8'd127, 8'd127, 8'd0);
      exp_q.push_back({1'b1, 8'h80});
      send_pair(8'd127, 8'h80, 8'd0);
      send_pair(8'd127, 8'h80, 8'd0);
      in_valid = 1'b0;
      for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL sat_timeout: got %0d pending, expected 0", exp_q.size());
      end
   endtask

   task automatic test_stall_backpressure();
      z_ready = 1'b0;
      exp_q.push_back({1'b0, 8'd48});
      send_pair(8'd16, 8'd32, 8'hF0);
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL stall_state: got rdy=%0b busy=%0b expected 1 1", in_ready, busy);
         end
      end
      @(posedge clk); #1;
      send_pair(8'd16, 8'd32, 8'hF0);
      in_valid = 1'b0;
      for (int i = 0; i < 10 && !z_valid; i++) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (z_valid !== 1'b1 || z_value !== 8'd48 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_hold: got zv=%0b z=%0d rdy=%0b expected 1 48 0", z_valid, z_value, in_ready);
         end
      end
      @(posedge clk); #1;
      z_ready = 1'b1;
      exp_q.push_back({1'b0, 8'd32});
      send_pair(8'd16, 8'd16, 8'd0);
      checks++;
      if (acc_cyc != last_hs + 1) begin
         errors++; $display("FAIL next_frame_accept: got edge %0d expected %0d", acc_cyc, last_hs + 1);
      end
      send_pair(8'd16, 8'd16, 8'd0);
      in_valid = 1'b0;
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL stall_timeout: got %0d pending, expected 0", exp_q.size());
      end
   endtask

   task automatic test_reset_mid();
      int hs0;
      hs0 = hs_count;
      send_pair(8'd40, 8'd50, 8'd5);
      in_valid = 1'b0;
      checks++;
      if (busy !== 1'b1 || z_value !== 8'd32) begin
         errors++; $display("FAIL pre_reset: got busy=%0b z=%0d expected 1 32", busy, z_value);
      end
      #3 rst = 1'b1;
      #1;
      checks++;
      if (z_valid !== 1'b0 || busy !== 1'b0 || z_value !== 8'd0) begin
         errors++;
         $display("FAIL async_reset: got zv=%0b busy=%0b z=%0d expected 0 0 0", z_valid, busy, z_value);
      end
      @(posedge clk); #1 rst = 1'b0;
      exp_q.push_back({1'b0, 8'd48});
      send_pair(8'd16, 8'd32, 8'hF0);
      send_pair(8'd16, 8'd32, 8'hF0);
      in_valid = 1'b0;
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (hs_count != hs0 + 1) begin
         errors++; $display("FAIL reset_frame_outputs: got %0d expected 1", hs_count - hs0);
      end
   endtask

   task automatic test_back_to_back();
      int base;
      logic [7:0] b, x0, w0, x1, w1;
      base = hs_edges.size();
      z_ready = 1'b1;
      for (int f = 0; f < 5; f++) begin
         b  = 8'($urandom_range(0, 255));
         x0 = 8'($urandom_range(0, 255)); w0 = 8'($urandom_range(0, 255));
         x1 = 8'($urandom_range(0, 255)); w1 = 8'($urandom_range(0, 255));
         exp_q.push_back(model(b, x0, w0, x1, w1));
         send_pair(x0, w0, b);
         send_pair(x1, w1, b);
      end
      in_valid = 1'b0;
      for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      checks++;
      if (hs_edges.size() != base + 5) begin
         errors++; $display("FAIL stream_count: got %0d expected 5", hs_edges.size() - base);
      end else begin
         for (int k = 1; k < 5; k++) begin
            checks++;
            if (hs_edges[base+k] - hs_edges[base+k-1] != 4) begin
               errors++;
               $display("FAIL stream_period: frame %0d got %0d cycles expected 4", k,
                        hs_edges[base+k] - hs_edges[base+k-1]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_xor();
      test_rounding();
      test_saturation();
      test_stall_backpressure();
      test_reset_mid();
      test_back_to_back();
      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
